csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the single-issue core; successor to the fixed 64-bit, timer-only CSR block.
- Adds: XLEN generalisation, three prioritised interrupt sources (MEI/MSI/MTI), vectored mtvec mode, illegal-CSR-access exception, and mcountinhibit-gated counters.
- Sits beside the execute stage. It decodes CSR ops of the current instruction, raises trap/mret redirects to the fetch unit, and exports architectural state for difftest.

Parameters:
- XLEN, 64, data/CSR width; legal values are 32 or 64.
- VECTORED_EN, 1, 1 allows mtvec.MODE=1; 0 hardwires MODE to 0.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst_valid  in  1  current instruction retires-or-traps this cycle.
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC.
- csr_index  in  12  CSR address.
- csr_wdata  in  XLEN  operand; rs1 value or zero-extended uimm, already muxed.
- inst_pc  in  XLEN  PC of current instruction.
- inst_ecall  in  1  ecall decoded.
- inst_ebreak  in  1  ebreak decoded.
- inst_mret  in  1  mret decoded.
- irq_mtip  in  1  timer interrupt level.
- irq_msip  in  1  software interrupt level.
- irq_meip  in  1  external interrupt level.
- csr_rdata  out  XLEN  old CSR value, combinational.
- trap_valid  out  1  redirect fetch this cycle (trap or mret).
- trap_pc  out  XLEN  redirect target.
- csr_illegal  out  1  current CSR access is illegal.
- mstatus_o, mtvec_o, mepc_o, mcause_o, mip_o, mie_o, mscratch_o  out  XLEN each  difftest taps.

Behaviour:
- Reset: one edge with rst=1 gives the following values.
  - mstatus=0x1800 (MPP=11, hardwired).
  - mtvec, mepc, mcause, mie, mscratch, mcycle, minstret, mcountinhibit = 0.
  - While rst=1, trap_valid=0 and csr_illegal=0. Reset applied mid-instruction discards any pending update.
- Implemented CSRs: mstatus (MIE b3, MPIE b7 writable; all other bits read 0 except MPP=11), misa, mvendorid=0, marchid=0, mimpid=0, mhartid=HART_ID, mtvec, mepc, mcause, mip, mie, mscratch, mcycle, minstret, mcountinhibit (CY b0, IR b2).
- mip is read-only: b11=irq_meip, b7=irq_mtip, b3=irq_msip, sampled live. Only mie b3/b7/b11 are writable.
- mtvec writes:
  - MODE value 2 or 3 keeps the old MODE.
  - VECTORED_EN=0 forces MODE=0.
  - BASE is bits XLEN-1:2.
- mepc bits 1:0 always read 0.
- Write value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - A write is attempted when op=RW, or when op is RS/RC and wdata!=0.
- csr_illegal=1 when inst_valid and op!=00 and either the index is unimplemented, or a write is attempted to 0xF11-0xF14 (mvendorid..mhartid).
- Trap priority within one valid instruction, highest first:
  1. Interrupt, when mstatus.MIE=1 and (mip&mie)!=0. Among sources, MEI(11) > MSI(3) > MTI(7).
  2. Illegal CSR access, cause 2.
  3. ecall, cause 11.
  4. ebreak, cause 3.
- Trap taken:
  - trap_valid=1 in the same cycle.
  - CSR write and mret of that instruction are suppressed.
  - At the next edge: mepc=inst_pc, mcause={intr,code}. The interrupt flag is bit XLEN-1.
  - At the next edge: MPIE=MIE, MIE=0.
- Trap target:
  - MODE=0, or any exception: {BASE,2'b00}.
  - MODE=1 and interrupt: {BASE,2'b00}+4*code, truncated to XLEN.
- mret without a trap: trap_valid=1, trap_pc=mepc. At the next edge MIE=MPIE, MPIE=1.
- mret executed while an interrupt is pending and MIE=0: mret completes normally. The interrupt is taken on the next valid instruction once MIE=1.
- Counters:
  - mcycle increments every cycle unless CY=1.
  - minstret increments when inst_valid, no trap is taken, and IR=0. mret counts as retired.
  - Both wrap from all-ones to 0.
  - An explicit CSR write wins over the increment in the same cycle.
- Read/write timing: csr_rdata returns the pre-write value in the same cycle (0 for an illegal index). Writes are visible from the next cycle.
- inst_valid=0: no state change except mcycle; trap_valid=0.

Test Plan:
1. Reset, then read every CSR -> mstatus=0x1800, mhartid=HART_ID, all others 0. A csrrw to mscratch with 0xDEAD reads back 0xDEAD on the next instruction.
2. mtvec=0x8000_0001, mstatus.MIE=1, mie=0x888, irq_mtip=1 and irq_meip=1 together at pc 0x8000_0100 -> trap_pc=0x8000_002C, mcause=0x8000_0000_0000_000B (XLEN=64), mepc=0x8000_0100, MIE=0, MPIE=1.
3. ecall at pc 0x200 with mtvec=0x1001 -> trap_pc=0x1000, mcause=11. A following mret -> trap_pc=0x200, MIE restored.
4. csrrs x0→mvendorid with wdata=0 -> no trap, rdata=0. csrrw to mvendorid -> trap, mcause=2. Access to index 0x7C0 -> trap, mcause=2.
5. mcountinhibit=0x1 -> mcycle holds across 10 cycles. Writing minstret=all-ones, then one retired instruction -> minstret=0.
6. Interrupt coincident with csrrw mscratch=5 -> trap taken, mscratch unchanged, minstret unchanged.

Source files
------------

// File: rtl/csr_trap_unit_if.sv
// Execute-stage <-> CSR/trap unit bundle: instruction side, redirect side and difftest taps.
interface csr_trap_unit_if #(
    parameter int XLEN = 64
);
    logic            inst_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_index;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ecall;
    logic            inst_ebreak;
    logic            inst_mret;
    logic            irq_mtip;
    logic            irq_msip;
    logic            irq_meip;

    logic [XLEN-1:0] csr_rdata;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            csr_illegal;

    logic [XLEN-1:0] mstatus_o;
    logic [XLEN-1:0] mtvec_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mip_o;
    logic [XLEN-1:0] mie_o;
    logic [XLEN-1:0] mscratch_o;

    // Execute stage / interrupt sources drive the instruction side.
    modport master (
        output inst_valid, csr_op, csr_index, csr_wdata, inst_pc,
               inst_ecall, inst_ebreak, inst_mret, irq_mtip, irq_msip, irq_meip,
        input  csr_rdata, trap_valid, trap_pc, csr_illegal,
               mstatus_o, mtvec_o, mepc_o, mcause_o, mip_o, mie_o, mscratch_o
    );

    // The CSR/trap unit consumes the instruction side and answers.
    modport slave (
        input  inst_valid, csr_op, csr_index, csr_wdata, inst_pc,
               inst_ecall, inst_ebreak, inst_mret, irq_mtip, irq_msip, irq_meip,
        output csr_rdata, trap_valid, trap_pc, csr_illegal,
               mstatus_o, mtvec_o, mepc_o, mcause_o, mip_o, mie_o, mscratch_o
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: decodes CSR ops, prioritises
// interrupts/exceptions, produces trap and mret redirects, runs mcycle/minstret.
module csr_trap_unit #(
    parameter int XLEN        = 64,
    parameter bit VECTORED_EN = 1'b1,
    parameter int HART_ID     = 0
) (
    input  logic           clk,
    input  logic           rst,
    csr_trap_unit_if.slave bus
);
    typedef logic [XLEN-1:0] word_t;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTIN = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MVENDOR  = 12'hF11;
    localparam logic [11:0] ADDR_MARCH    = 12'hF12;
    localparam logic [11:0] ADDR_MIMP     = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam word_t MSTATUS_FIXED = word_t'('h1800);   // MPP=11, read-only
    localparam word_t MSTATUS_WMASK = word_t'('h88);     // MPIE, MIE
    localparam word_t MIE_WMASK     = word_t'('h888);    // MEIE, MTIE, MSIE
    localparam word_t MCOUNTIN_MASK = word_t'('h5);      // IR, CY
    localparam word_t ALIGN_MASK    = ~word_t'(3);

    word_t mstatus_reg, mstatus_next;
    word_t mtvec_reg, mtvec_next;
    word_t mepc_reg, mepc_next;
    word_t mcause_reg, mcause_next;
    word_t mie_reg, mie_next;
    word_t mscratch_reg, mscratch_next;
    word_t mcycle_reg, mcycle_next;
    word_t minstret_reg, minstret_next;
    word_t mcountin_reg, mcountin_next;

    word_t      mip_val, old_val, wval, pending, trap_base;
    logic       impl, write_attempt, ro_index, illegal;
    logic       irq_any, int_take, exc_take, trap_take, mret_take, csr_wr_en;
    logic [3:0] irq_code, exc_code, cause_code;
    logic       mtvec_mode_wr;

    // mip mirrors the interrupt lines live; only bits 11/7/3 exist.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_mip
            if (gi == 11) begin : g_mei
                assign mip_val[gi] = bus.irq_meip;
            end else if (gi == 7) begin : g_mti
                assign mip_val[gi] = bus.irq_mtip;
            end else if (gi == 3) begin : g_msi
                assign mip_val[gi] = bus.irq_msip;
            end else begin : g_zero
                assign mip_val[gi] = 1'b0;
            end
        end
    endgenerate

    // CSR read mux: pre-write value, 0 and impl=0 for unknown indices.
    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        case (bus.csr_index)
            ADDR_MSTATUS:  old_val = mstatus_reg;
            ADDR_MISA:     old_val = '0;
            ADDR_MIE:      old_val = mie_reg;
            ADDR_MTVEC:    old_val = mtvec_reg;
            ADDR_MCOUNTIN: old_val = mcountin_reg;
            ADDR_MSCRATCH: old_val = mscratch_reg;
            ADDR_MEPC:     old_val = mepc_reg;
            ADDR_MCAUSE:   old_val = mcause_reg;
            ADDR_MIP:      old_val = mip_val;
            ADDR_MCYCLE:   old_val = mcycle_reg;
            ADDR_MINSTRET: old_val = minstret_reg;
            ADDR_MVENDOR:  old_val = '0;
            ADDR_MARCH:    old_val = '0;
            ADDR_MIMP:     old_val = '0;
            ADDR_MHARTID:  old_val = word_t'(HART_ID);
            default:       impl    = 1'b0;
        endcase
    end

    // Read-modify-write value for RW/RS/RC.
    always_comb begin
        case (bus.csr_op)
            2'b01:   wval = bus.csr_wdata;
            2'b10:   wval = old_val | bus.csr_wdata;
            2'b11:   wval = old_val & ~bus.csr_wdata;
            default: wval = old_val;
        endcase
    end

    assign write_attempt = (bus.csr_op == 2'b01) ||
                           ((bus.csr_op[1] == 1'b1) && (bus.csr_wdata != '0));
    assign ro_index      = (bus.csr_index >= ADDR_MVENDOR) && (bus.csr_index <= ADDR_MHARTID);
    assign illegal       = bus.inst_valid && (bus.csr_op != 2'b00) &&
                           (!impl || (write_attempt && ro_index));

    // Interrupt source priority: MEI > MSI > MTI.
    assign pending = mip_val & mie_reg;
    assign irq_any = |pending;
    always_comb begin
        irq_code = 4'd0;
        if (pending[11])     irq_code = 4'd11;
        else if (pending[3]) irq_code = 4'd3;
        else if (pending[7]) irq_code = 4'd7;
    end

    // Exception priority: illegal CSR > ecall > ebreak.
    always_comb begin
        exc_code = 4'd0;
        if (illegal)              exc_code = 4'd2;
        else if (bus.inst_ecall)  exc_code = 4'd11;
        else if (bus.inst_ebreak) exc_code = 4'd3;
    end

    assign int_take   = bus.inst_valid && mstatus_reg[3] && irq_any;
    assign exc_take   = illegal || (bus.inst_valid && (bus.inst_ecall || bus.inst_ebreak));
    assign trap_take  = int_take || exc_take;
    assign cause_code = int_take ? irq_code : exc_code;
    assign mret_take  = bus.inst_valid && bus.inst_mret && !trap_take;
    assign csr_wr_en  = bus.inst_valid && write_attempt && !trap_take;
    assign trap_base  = mtvec_reg & ALIGN_MASK;

    // MODE 2/3 is reserved, so such writes leave the current mode in place.
    assign mtvec_mode_wr = VECTORED_EN ? (wval[1] ? mtvec_reg[0] : wval[0]) : 1'b0;

    // Next architectural state: counters, then CSR write, then trap/mret side effects.
    always_comb begin
        mstatus_next  = mstatus_reg;
        mtvec_next    = mtvec_reg;
        mepc_next     = mepc_reg;
        mcause_next   = mcause_reg;
        mie_next      = mie_reg;
        mscratch_next = mscratch_reg;
        mcountin_next = mcountin_reg;
        mcycle_next   = mcountin_reg[0] ? mcycle_reg : mcycle_reg + 1'b1;
        minstret_next = (bus.inst_valid && !trap_take && !mcountin_reg[2]) ?
                        minstret_reg + 1'b1 : minstret_reg;
        if (csr_wr_en) begin
            case (bus.csr_index)
                ADDR_MSTATUS:  mstatus_next  = (wval & MSTATUS_WMASK) | MSTATUS_FIXED;
                ADDR_MIE:      mie_next      = wval & MIE_WMASK;
                ADDR_MTVEC:    mtvec_next    = (wval & ALIGN_MASK) | word_t'(mtvec_mode_wr);
                ADDR_MCOUNTIN: mcountin_next = wval & MCOUNTIN_MASK;
                ADDR_MSCRATCH: mscratch_next = wval;
                ADDR_MEPC:     mepc_next     = wval & ALIGN_MASK;
                ADDR_MCAUSE:   mcause_next   = wval;
                ADDR_MCYCLE:   mcycle_next   = wval;
                ADDR_MINSTRET: minstret_next = wval;
                default:       ;
            endcase
        end
        if (trap_take) begin
            mepc_next       = bus.inst_pc & ALIGN_MASK;
            mcause_next     = {int_take, {(XLEN-5){1'b0}}, cause_code};
            mstatus_next[7] = mstatus_reg[3];
            mstatus_next[3] = 1'b0;
        end
        if (mret_take) begin
            mstatus_next[3] = mstatus_reg[7];
            mstatus_next[7] = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_reg  <= MSTATUS_FIXED;
            mtvec_reg    <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mie_reg      <= '0;
            mscratch_reg <= '0;
            mcycle_reg   <= '0;
            minstret_reg <= '0;
            mcountin_reg <= '0;
        end else begin
            mstatus_reg  <= mstatus_next;
            mtvec_reg    <= mtvec_next;
            mepc_reg     <= mepc_next;
            mcause_reg   <= mcause_next;
            mie_reg      <= mie_next;
            mscratch_reg <= mscratch_next;
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
            mcountin_reg <= mcountin_next;
        end
    end

    assign bus.csr_rdata   = old_val;
    assign bus.trap_valid  = !rst && (trap_take || mret_take);
    assign bus.trap_pc     = trap_take ? ((int_take && mtvec_reg[0]) ?
                                          trap_base + (word_t'(irq_code) << 2) : trap_base)
                                       : mepc_reg;
    assign bus.csr_illegal = !rst && illegal;
    assign bus.mstatus_o   = mstatus_reg;
    assign bus.mtvec_o     = mtvec_reg;
    assign bus.mepc_o      = mepc_reg;
    assign bus.mcause_o    = mcause_reg;
    assign bus.mip_o       = mip_val;
    assign bus.mie_o       = mie_reg;
    assign bus.mscratch_o  = mscratch_reg;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed vector bench for csr_trap_unit (XLEN=64, vectored, HART_ID=5).
module tb_csr_trap_unit;
    localparam int XLEN = 64;
    localparam int HART = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_trap_unit_if #(.XLEN(XLEN)) bus();

    csr_trap_unit #(.XLEN(XLEN), .VECTORED_EN(1'b1), .HART_ID(HART)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] idx;
        logic [63:0] wd;
        logic [63:0] pc;
        logic        ecall;
        logic        ebreak;
        logic        mret;
        logic [2:0]  irq;        // {meip, msip, mtip}
        logic [63:0] exp_rdata;
        logic        exp_tv;
        logic [63:0] exp_tpc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
    localparam logic [63:0] ONES = '1;

    function automatic void add(input logic valid, input logic [1:0] op, input logic [11:0] idx,
                                input logic [63:0] wd, input logic [63:0] pc, input logic ecall,
                                input logic ebreak, input logic mret, input logic [2:0] irq,
                                input logic [63:0] exp_rdata, input logic exp_tv,
                                input logic [63:0] exp_tpc, input logic exp_ill);
        vec_t v;
        v.valid = valid; v.op = op; v.idx = idx; v.wd = wd; v.pc = pc;
        v.ecall = ecall; v.ebreak = ebreak; v.mret = mret; v.irq = irq;
        v.exp_rdata = exp_rdata; v.exp_tv = exp_tv; v.exp_tpc = exp_tpc; v.exp_ill = exp_ill;
        vecs.push_back(v);
    endfunction

    function automatic void add_rd(input logic [11:0] idx, input logic [2:0] irq, input logic [63:0] exp);
        add(1'b1, OP_RS, idx, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, irq, exp, 1'b0, 64'h0, 1'b0);
    endfunction

    function automatic void add_op(input logic [1:0] op, input logic [11:0] idx, input logic [63:0] wd,
                                   input logic [63:0] exp);
        add(1'b1, op, idx, wd, 64'h0, 1'b0, 1'b0, 1'b0, 3'b000, exp, 1'b0, 64'h0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [1:0] op, input logic [11:0] idx,
                         input logic [63:0] wd, input logic [63:0] pc, input logic ecall,
                         input logic ebreak, input logic mret, input logic [2:0] irq);
        bus.inst_valid  = valid;
        bus.csr_op      = op;
        bus.csr_index   = idx;
        bus.csr_wdata   = wd;
        bus.inst_pc     = pc;
        bus.inst_ecall  = ecall;
        bus.inst_ebreak = ebreak;
        bus.inst_mret   = mret;
        bus.irq_meip    = irq[2];
        bus.irq_msip    = irq[1];
        bus.irq_mtip    = irq[0];
    endtask

    task automatic idle();
        drive(1'b0, OP_NONE, 12'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    // One legal CSR instruction: drive, check rdata just after drive, advance to next negedge.
    task automatic step(input string name, input logic [1:0] op, input logic [11:0] idx,
                        input logic [63:0] wd, input logic [2:0] irq, input logic chk,
                        input logic [63:0] exp);
        drive(1'b1, op, idx, wd, 64'h0, 1'b0, 1'b0, 1'b0, irq);
        #1;
        if (chk) check(name, bus.csr_rdata, exp);
        $display("step %s idx=%h rdata=%h", name, idx, bus.csr_rdata);
        @(negedge clk);
    endtask

    initial begin
        // Reset values, identity CSRs, mscratch round trip
        add_rd(12'hB02, 3'b000, 64'h0);
        add_rd(12'hB00, 3'b000, 64'h1);
        add_rd(12'h300, 3'b000, 64'h1800);
        add_rd(12'h301, 3'b000, 64'h0);
        add_rd(12'h304, 3'b000, 64'h0);
        add_rd(12'h305, 3'b000, 64'h0);
        add_rd(12'h320, 3'b000, 64'h0);
        add_rd(12'h340, 3'b000, 64'h0);
        add_rd(12'h341, 3'b000, 64'h0);
        add_rd(12'h342, 3'b000, 64'h0);
        add_rd(12'h344, 3'b000, 64'h0);
        add_rd(12'hF11, 3'b000, 64'h0);
        add_rd(12'hF12, 3'b000, 64'h0);
        add_rd(12'hF13, 3'b000, 64'h0);
        add_rd(12'hF14, 3'b000, 64'h5);
        add_op(OP_RW, 12'h340, 64'hDEAD, 64'h0);
        add_rd(12'h340, 3'b000, 64'hDEAD);
        // ecall / mret round trip with MIE save and restore
        add_op(OP_RW, 12'h305, 64'h1001, 64'h0);
        add_op(OP_RS, 12'h300, 64'h8, 64'h1800);
        add(1, OP_NONE, 12'h0, 0, 64'h200, 1, 0, 0, 3'b000, 64'h0, 1, 64'h1000, 0);
        add_rd(12'h342, 3'b000, 64'hB);
        add_rd(12'h341, 3'b000, 64'h200);
        add_rd(12'h300, 3'b000, 64'h1880);
        add(1, OP_NONE, 12'h0, 0, 64'h1004, 0, 0, 1, 3'b000, 64'h0, 1, 64'h200, 0);
        add_rd(12'h300, 3'b000, 64'h1888);
        // Illegal CSR access
        add_rd(12'hF11, 3'b000, 64'h0);
        add(1, OP_RW, 12'hF11, 64'h1, 64'h300, 0, 0, 0, 3'b000, 64'h0, 1, 64'h1000, 1);
        add_rd(12'h342, 3'b000, 64'h2);
        add(1, OP_NONE, 12'h0, 0, 64'h1008, 0, 0, 1, 3'b000, 64'h0, 1, 64'h300, 0);
        add(1, OP_NONE, 12'h0, 0, 64'h400, 1, 0, 0, 3'b000, 64'h0, 1, 64'h1000, 0);
        add(1, OP_RS, 12'h7C0, 0, 64'h404, 0, 0, 0, 3'b000, 64'h0, 1, 64'h1000, 1);
        add_rd(12'h342, 3'b000, 64'h2);
        add_rd(12'h300, 3'b000, 64'h1800);
        // ebreak and exception priority
        add(1, OP_NONE, 12'h0, 0, 64'h500, 0, 1, 0, 3'b000, 64'h0, 1, 64'h1000, 0);
        add_rd(12'h342, 3'b000, 64'h3);
        add(1, OP_NONE, 12'h0, 0, 64'h504, 1, 1, 0, 3'b000, 64'h0, 1, 64'h1000, 0);
        add_rd(12'h342, 3'b000, 64'hB);
        add(1, OP_RW, 12'hF14, 0, 64'h508, 1, 0, 0, 3'b000, 64'h5, 1, 64'h1000, 1);
        add_rd(12'h342, 3'b000, 64'h2);
        // inst_valid=0 has no effect
        add(0, OP_RW, 12'h340, 64'h99, 64'h50C, 1, 0, 0, 3'b000, 64'hDEAD, 0, 64'h0, 0);
        add_rd(12'h342, 3'b000, 64'h2);
        // mtvec mode WARL, mepc alignment, RC, write masks
        add_op(OP_RW, 12'h305, 64'h2003, 64'h1001);
        add_rd(12'h305, 3'b000, 64'h2001);
        add_op(OP_RW, 12'h305, 64'h1000, 64'h2001);
        add_op(OP_RW, 12'h305, 64'h8000_0001, 64'h1000);
        add_rd(12'h305, 3'b000, 64'h8000_0001);
        add_op(OP_RW, 12'h341, 64'h1237, 64'h508);
        add_rd(12'h341, 3'b000, 64'h1234);
        add_op(OP_RC, 12'h340, 64'hAD, 64'hDEAD);
        add_rd(12'h340, 3'b000, 64'hDE00);
        add_op(OP_RW, 12'h304, ONES, 64'h0);
        add_rd(12'h304, 3'b000, 64'h888);
        add_op(OP_RW, 12'h300, ONES, 64'h1800);
        add_rd(12'h300, 3'b000, 64'h1888);
        // Vectored interrupt, MEI beats MTI
        add(1, OP_NONE, 12'h0, 0, 64'h8000_0100, 0, 0, 0, 3'b101, 64'h0, 1, 64'h8000_002C, 0);
        add_rd(12'h342, 3'b101, 64'h8000_0000_0000_000B);
        add_rd(12'h341, 3'b101, 64'h8000_0100);
        add_rd(12'h300, 3'b101, 64'h1880);
        add_rd(12'h344, 3'b101, 64'h880);
        add_rd(12'h344, 3'b111, 64'h888);
        // mret with MIE=0 and an interrupt pending completes; the interrupt follows
        add(1, OP_NONE, 12'h0, 0, 64'h1010, 0, 0, 1, 3'b001, 64'h0, 1, 64'h8000_0100, 0);
        add(1, OP_NONE, 12'h0, 0, 64'h600, 0, 0, 0, 3'b011, 64'h0, 1, 64'h8000_000C, 0);
        add_rd(12'h342, 3'b000, 64'h8000_0000_0000_0003);
        add_rd(12'h300, 3'b000, 64'h1880);

        // Outputs held quiet while in reset
        drive(1'b1, OP_RW, 12'hF11, 64'h1, 64'h40, 1'b1, 1'b0, 1'b0, 3'b111);
        rst = 1'b1;
        #1;
        check("rst_trap_valid", {63'b0, bus.trap_valid}, 64'h0);
        check("rst_illegal", {63'b0, bus.csr_illegal}, 64'h0);
        $display("reset trap_valid=%b csr_illegal=%b", bus.trap_valid, bus.csr_illegal);
        @(negedge clk);
        rst = 1'b0;
        idle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].idx, vecs[i].wd, vecs[i].pc,
                  vecs[i].ecall, vecs[i].ebreak, vecs[i].mret, vecs[i].irq);
            #1;
            check($sformatf("vec%0d_rdata", i), bus.csr_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_trap_valid", i), {63'b0, bus.trap_valid}, {63'b0, vecs[i].exp_tv});
            check($sformatf("vec%0d_illegal", i), {63'b0, bus.csr_illegal}, {63'b0, vecs[i].exp_ill});
            if (vecs[i].exp_tv)
                check($sformatf("vec%0d_trap_pc", i), bus.trap_pc, vecs[i].exp_tpc);
            $display("vec %0d idx=%h op=%b rdata=%h tv=%b tpc=%h ill=%b", i, vecs[i].idx,
                     vecs[i].op, bus.csr_rdata, bus.trap_valid, bus.trap_pc, bus.csr_illegal);
            @(negedge clk);
        end

        // mcountinhibit.CY freezes mcycle; explicit write beats increment
        step("inhibit_cy", OP_RW, 12'h320, 64'h1, 3'b000, 1'b1, 64'h0);
        step("mcycle_wr", OP_RW, 12'hB00, 64'h100, 3'b000, 1'b0, 64'h0);
        idle();
        repeat (10) @(negedge clk);
        step("mcycle_held", OP_RS, 12'hB00, 64'h0, 3'b000, 1'b1, 64'h100);
        step("uninhibit", OP_RW, 12'h320, 64'h0, 3'b000, 1'b1, 64'h1);
        step("mcycle_still", OP_RS, 12'hB00, 64'h0, 3'b000, 1'b1, 64'h100);
        idle();
        @(negedge clk);
        step("mcycle_run", OP_RS, 12'hB00, 64'h0, 3'b000, 1'b1, 64'h102);
        step("mcycle_wr2", OP_RW, 12'hB00, 64'h50, 3'b000, 1'b0, 64'h0);
        step("mcycle_wins", OP_RS, 12'hB00, 64'h0, 3'b000, 1'b1, 64'h50);

        // minstret wrap and IR inhibit
        step("minstret_ones", OP_RW, 12'hB02, ONES, 3'b000, 1'b0, 64'h0);
        step("retire_nop", OP_NONE, 12'h0, 64'h0, 3'b000, 1'b1, 64'h0);
        step("minstret_wrap", OP_RS, 12'hB02, 64'h0, 3'b000, 1'b1, 64'h0);
        step("inhibit_ir", OP_RW, 12'h320, 64'h4, 3'b000, 1'b1, 64'h0);
        step("retire_nop2", OP_NONE, 12'h0, 64'h0, 3'b000, 1'b0, 64'h0);
        step("minstret_held", OP_RS, 12'hB02, 64'h0, 3'b000, 1'b1, 64'h2);
        step("uninhibit_ir", OP_RW, 12'h320, 64'h0, 3'b000, 1'b1, 64'h4);

        // Interrupt coincident with csrrw mscratch: write and retire suppressed
        step("mscratch_11", OP_RW, 12'h340, 64'h11, 3'b000, 1'b1, 64'hDE00);
        step("minstret_40", OP_RW, 12'hB02, 64'h40, 3'b000, 1'b0, 64'h0);
        step("set_mie", OP_RS, 12'h300, 64'h8, 3'b000, 1'b1, 64'h1880);
        drive(1'b1, OP_RW, 12'h340, 64'h5, 64'h700, 1'b0, 1'b0, 1'b0, 3'b010);
        #1;
        check("irq_csr_trap_valid", {63'b0, bus.trap_valid}, 64'h1);
        check("irq_csr_trap_pc", bus.trap_pc, 64'h8000_000C);
        check("irq_csr_illegal", {63'b0, bus.csr_illegal}, 64'h0);
        $display("irq+csrrw trap_valid=%b trap_pc=%h", bus.trap_valid, bus.trap_pc);
        @(negedge clk);
        idle();
        #1;
        check("tap_mscratch", bus.mscratch_o, 64'h11);
        check("tap_mepc", bus.mepc_o, 64'h700);
        check("tap_mcause", bus.mcause_o, 64'h8000_0000_0000_0003);
        check("tap_mstatus", bus.mstatus_o, 64'h1880);
        check("tap_mtvec", bus.mtvec_o, 64'h8000_0001);
        check("tap_mie", bus.mie_o, 64'h888);
        check("tap_mip", bus.mip_o, 64'h0);
        $display("taps mstatus=%h mepc=%h mcause=%h", bus.mstatus_o, bus.mepc_o, bus.mcause_o);
        @(negedge clk);
        step("minstret_kept", OP_RS, 12'hB02, 64'h0, 3'b000, 1'b1, 64'h41);
        step("mscratch_kept", OP_RS, 12'h340, 64'h0, 3'b000, 1'b1, 64'h11);

        // Reset in the middle of a write discards it and restores reset values
        drive(1'b1, OP_RW, 12'h340, 64'h77, 64'h800, 1'b0, 1'b0, 1'b0, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_mscratch", OP_RS, 12'h340, 64'h0, 3'b000, 1'b1, 64'h0);
        step("post_rst_mstatus", OP_RS, 12'h300, 64'h0, 3'b000, 1'b1, 64'h1800);
        step("post_rst_mtvec", OP_RS, 12'h305, 64'h0, 3'b000, 1'b1, 64'h0);
        step("post_rst_mie", OP_RS, 12'h304, 64'h0, 3'b000, 1'b1, 64'h0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
